rf_wport_arbiter: RTL

Shares the register file's single write port between the WB stage and a one-entry-at-a-time long-latency unit (divider/CSR return path, "LU"). LU results are buffered in a 2-entry FIFO and drained into idle write-port cycles. A starvation counter forces a one-cycle WB hold when the FIFO has waited too long. The block also drives the debug trace and reports pending-register hits to ID.

---
 rtl/rf_wport_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has priority, LU results wait in a 2-entry FIFO
// and drain into idle slots; a starvation counter forces a one-cycle WB hold.
module rf_wport_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic [31:0] wb_pc,
  output logic        wb_hold,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  input  logic [31:0] lu_pc,
  input  logic [4:0]  id_raddr1,
  input  logic [4:0]  id_raddr2,
  input  logic [4:0]  id_waddr,
  output logic        id_pend_hit,
  output logic [1:0]  pend_cnt,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  typedef enum logic {ARB, HOLD} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);

  state_t      state;
  logic [4:0]  q_waddr [2];
  logic [31:0] q_wdata [2];
  logic [31:0] q_pc    [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic [3:0]  starve;

  logic        hold, push, pop, grant_wb, go_hold, granted;
  logic [1:0]  ent_vld;
  logic [4:0]  g_waddr;
  logic [31:0] g_wdata, g_pc;

  assign hold     = (state == HOLD);
  assign lu_ready = ~reset & (count != 2'd2);
  assign push     = lu_valid & lu_ready;
  assign pop      = ~reset & (count != 2'd0) & (hold | ~wb_we);
  assign grant_wb = ~reset & ~hold & wb_we;
  assign granted  = pop | grant_wb;
  assign go_hold  = ~hold & (count != 2'd0) & ~pop & (starve == STARVE_MAX);

  always_comb begin
    g_waddr = 5'd0;
    g_wdata = 32'd0;
    g_pc    = 32'd0;
    if (pop) begin
      g_waddr = q_waddr[rd_ptr];
      g_wdata = q_wdata[rd_ptr];
      g_pc    = q_pc[rd_ptr];
    end else if (grant_wb) begin
      g_waddr = wb_waddr;
      g_wdata = wb_wdata;
      g_pc    = wb_pc;
    end
  end

  // r0 writes still consume the slot; only the enable is dropped
  assign rf_we             = granted & (g_waddr != 5'd0);
  assign rf_waddr          = g_waddr;
  assign rf_wdata          = g_wdata;
  assign debug_wb_pc       = g_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = g_waddr;
  assign debug_wb_rf_wdata = g_wdata;

  assign wb_hold  = hold & ~reset;
  assign pend_cnt = reset ? 2'd0 : count;

  assign ent_vld[0] = (count == 2'd2) | ((count == 2'd1) & ~rd_ptr);
  assign ent_vld[1] = (count == 2'd2) | ((count == 2'd1) & rd_ptr);

  always_comb begin
    id_pend_hit = 1'b0;
    for (int i = 0; i < 2; i++)
      if (ent_vld[i] && q_waddr[i] != 5'd0 &&
          (q_waddr[i] == id_raddr1 || q_waddr[i] == id_raddr2 || q_waddr[i] == id_waddr))
        id_pend_hit = 1'b1;
    if (reset) id_pend_hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_waddr[wr_ptr] <= lu_waddr;
      q_wdata[wr_ptr] <= lu_wdata;
      q_pc[wr_ptr]    <= lu_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARB;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      starve <= 4'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
      if (pop || count == 2'd0 || hold) starve <= 4'd0;
      else if (starve != 4'hf)          starve <= starve + 4'd1;
      state <= go_hold ? HOLD : ARB;
    end
  end

endmodule
